store_splitter: RTL and testbench
=================================

STORE_SPLITTER -- requirements
Module: store_splitter

Interface
REQ-001 SHALL have parameter WORDLEN, default 64, giving the bus word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADRLEN, default 32, giving the physical address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ReqValid, input, 1 bit: a store request is present.
REQ-006 SHALL have port ReqReady, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have port ReqSize, input, 3 bits: 00 byte, 01 half, 10 word, 11 double; bit 2 is ignored.
REQ-008 SHALL have port ReqAdr, input, ADRLEN bits: byte address of the store.
REQ-009 SHALL have port ReqData, input, WORDLEN bits: store data, right-aligned (LSB = lowest-address byte).
REQ-010 SHALL have port BusValid, output, 1 bit: a bus write beat is present.
REQ-011 SHALL have port BusReady, input, 1 bit: the bus accepts the beat.
REQ-012 SHALL have port BusAdr, output, ADRLEN bits: word-aligned beat address.
REQ-013 SHALL have port BusData, output, WORDLEN bits: byte-lane-aligned write data.
REQ-014 SHALL have port BusByteMask, output, WORDLEN/8 bits: byte write enables.
REQ-015 SHALL have port BusLast, output, 1 bit: the beat is the final beat of its request.
REQ-016 SHALL have port MisalignCount, output, 16 bits: saturating count of split requests.

Function
REQ-017 SHALL implement states IDLE, FIRST and SECOND.
REQ-018 SHALL drive ReqReady = (state==IDLE) | (BusValid & BusReady & BusLast), so a new request can be accepted in the cycle the last beat completes.
REQ-019 SHALL treat a handshake as ReqValid & ReqReady; on a handshake it registers the request and enters FIRST in the next cycle, so BusValid rises one cycle after acceptance.
REQ-020 SHALL use effective size S = ReqSize[1:0]; when WORDLEN=32, S=11 is treated as 10.
REQ-021 SHALL form a 2*WORDLEN/8-bit mask, ((2^(2^S))-1) << off, where off = ReqAdr mod (WORDLEN/8).
REQ-022 SHALL form 2*WORDLEN-bit data as zero-extended ReqData << (8*off).
REQ-023 SHALL mark the request as split iff the upper half of the mask is nonzero.
REQ-024 SHALL, in FIRST, drive BusValid=1 with:
- BusAdr = ReqAdr with its low log2(WORDLEN/8) bits cleared;
- BusByteMask = lower mask half;
- BusData = lower data half;
- BusLast = !split.
REQ-025 SHALL, in SECOND, drive BusValid=1 with:
- BusAdr = first-beat address + WORDLEN/8, modulo 2^ADRLEN (wraps to 0);
- BusByteMask = upper mask half;
- BusData = upper data half;
- BusLast = 1.
REQ-026 SHALL, in FIRST on BusValid & BusReady, go to SECOND if split; otherwise go to FIRST if a new request is accepted that cycle, else to IDLE.
REQ-027 SHALL, in SECOND on BusValid & BusReady, go to FIRST if a new request is accepted that cycle, else to IDLE.
REQ-028 SHALL hold BusValid, BusAdr, BusData, BusByteMask and BusLast stable while BusValid & !BusReady.
REQ-029 SHALL hold BusValid=0 in IDLE, with BusByteMask=0 and BusLast=0.
REQ-030 SHALL ignore ReqSize, ReqAdr and ReqData whenever ReqReady=0.
REQ-031 SHALL increment MisalignCount by 1 on each accepted split request and saturate at 0xFFFF.
REQ-032 SHALL never drive a beat with an all-zero BusByteMask while BusValid=1.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set state=IDLE, BusValid=0, BusAdr=0, BusData=0, BusByteMask=0, BusLast=0 and MisalignCount=0.
REQ-034 SHALL, when reset is asserted mid-request (FIRST or SECOND), discard the remaining beats and start no bus beat in the following cycle.
REQ-035 SHALL hold ReqReady=1 while reset is asserted, but requests presented during reset are not accepted.

Verification (WORDLEN=64, ADRLEN=32)
REQ-036 SHALL cover an aligned double store: sd at 0x1000, data 0x1122334455667788 -> one beat, BusAdr 0x1000, mask 0xFF, data unchanged, BusLast=1, MisalignCount=0.
REQ-037 SHALL cover a split word store: sw at 0x1006, data 0xAABBCCDD, giving:
- beat 0: BusAdr 0x1000, mask 0xC0, data 0xCCDD000000000000, BusLast=0;
- beat 1: BusAdr 0x1008, mask 0x03, data 0x000000000000AABB, BusLast=1;
- MisalignCount=1.
REQ-038 SHALL cover backpressure: BusReady held low 3 cycles during beat 0 of the REQ-037 request -> all Bus* outputs stable and ReqReady=0 throughout.
REQ-039 SHALL cover back-to-back requests: sb at 0x2003, then sh at 0x2004 presented during beat 0 -> the second request is accepted in the handshake cycle; masks 0x08 then 0x30 on consecutive beats.
REQ-040 SHALL cover reset in SECOND: reset during beat 1 of a split request -> next cycle BusValid=0, ReqReady=1, MisalignCount=0.
REQ-041 SHALL cover address wrap: sh at 0xFFFFFFFF -> beat 0 at 0xFFFFFFF8 with mask 0x80, then beat 1 at 0x00000000 with mask 0x01 and BusLast=1.

Source files
------------

// File: rtl/store_splitter.sv
// rtl/store_splitter.sv - splits misaligned stores into one or two byte-masked bus beats
module store_splitter #(
   parameter int WORDLEN = 64,
   parameter int ADRLEN  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ReqValid,
   output logic                 ReqReady,
   input  logic [2:0]           ReqSize,
   input  logic [ADRLEN-1:0]    ReqAdr,
   input  logic [WORDLEN-1:0]   ReqData,
   output logic                 BusValid,
   input  logic                 BusReady,
   output logic [ADRLEN-1:0]    BusAdr,
   output logic [WORDLEN-1:0]   BusData,
   output logic [WORDLEN/8-1:0] BusByteMask,
   output logic                 BusLast,
   output logic [15:0]          MisalignCount
);

   localparam int NB   = WORDLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int MW   = 2 * NB;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FIRST  = 2'b01,
      SECOND = 2'b10
   } state_t;

   state_t state, state_next;

   logic [1:0]           eff_size;
   logic [OFFW-1:0]      off;
   logic [MW-1:0]        base_mask;
   logic [MW-1:0]        mask_full;
   logic [2*WORDLEN-1:0] data_full;
   logic                 split_now;
   logic [ADRLEN-1:0]    adr_aligned;

   logic                 split_q;
   logic [NB-1:0]        hi_mask_q;
   logic [WORDLEN-1:0]   hi_data_q;

   logic                 hs;
   logic                 beat_done;
   logic                 unused_size_msb;

   assign unused_size_msb = ReqSize[2];

   // Reset forces ready high so the requester sees an empty block, but nothing is accepted.
   assign ReqReady  = reset | (state == IDLE) | (BusValid & BusReady & BusLast);
   assign hs        = ReqValid & ReqReady & ~reset;
   assign beat_done = BusValid & BusReady;

   // Decode the incoming request into a double-width lane mask and shifted data.
   always_comb begin
      eff_size = ReqSize[1:0];
      if (WORDLEN == 32 && ReqSize[1:0] == 2'b11)
         eff_size = 2'b10;
      case (eff_size)
         2'b00:   base_mask = MW'(8'h01);
         2'b01:   base_mask = MW'(8'h03);
         2'b10:   base_mask = MW'(8'h0F);
         default: base_mask = MW'(8'hFF);
      endcase
      off         = ReqAdr[OFFW-1:0];
      mask_full   = base_mask << off;
      data_full   = {{WORDLEN{1'b0}}, ReqData} << {off, 3'b000};
      split_now   = |mask_full[MW-1:NB];
      adr_aligned = {ReqAdr[ADRLEN-1:OFFW], {OFFW{1'b0}}};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state: a beat completing either moves to the second half or to the next request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (hs)
               state_next = FIRST;
         end
         FIRST: begin
            if (beat_done) begin
               if (split_q)
                  state_next = SECOND;
               else if (hs)
                  state_next = FIRST;
               else
                  state_next = IDLE;
            end
         end
         SECOND: begin
            if (beat_done)
               state_next = hs ? FIRST : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Beat registers: load beat 0 on accept, swap in the upper half after a split first beat,
   // otherwise go quiet once the last beat has been taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         BusValid      <= 1'b0;
         BusAdr        <= '0;
         BusData       <= '0;
         BusByteMask   <= '0;
         BusLast       <= 1'b0;
         split_q       <= 1'b0;
         hi_mask_q     <= '0;
         hi_data_q     <= '0;
         MisalignCount <= '0;
      end else if (hs) begin
         BusValid    <= 1'b1;
         BusAdr      <= adr_aligned;
         BusByteMask <= mask_full[NB-1:0];
         BusData     <= data_full[WORDLEN-1:0];
         BusLast     <= ~split_now;
         split_q     <= split_now;
         hi_mask_q   <= mask_full[MW-1:NB];
         hi_data_q   <= data_full[2*WORDLEN-1:WORDLEN];
         if (split_now && MisalignCount != 16'hFFFF)
            MisalignCount <= MisalignCount + 16'd1;
      end else if (beat_done) begin
         if (state == FIRST && split_q) begin
            BusAdr      <= BusAdr + ADRLEN'(NB);
            BusByteMask <= hi_mask_q;
            BusData     <= hi_data_q;
            BusLast     <= 1'b1;
         end else begin
            BusValid    <= 1'b0;
            BusByteMask <= '0;
            BusLast     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_store_splitter.sv
// tb/tb_store_splitter.sv - directed self-checking bench for store_splitter
module tb_store_splitter;

   logic        clk;
   logic        reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [2:0]  ReqSize;
   logic [31:0] ReqAdr;
   logic [63:0] ReqData;
   logic        BusValid;
   logic        BusReady;
   logic [31:0] BusAdr;
   logic [63:0] BusData;
   logic [7:0]  BusByteMask;
   logic        BusLast;
   logic [15:0] MisalignCount;

   int checks = 0;
   int errors = 0;

   store_splitter #(.WORDLEN(64), .ADRLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqSize      (ReqSize),
      .ReqAdr       (ReqAdr),
      .ReqData      (ReqData),
      .BusValid     (BusValid),
      .BusReady     (BusReady),
      .BusAdr       (BusAdr),
      .BusData      (BusData),
      .BusByteMask  (BusByteMask),
      .BusLast      (BusLast),
      .MisalignCount(MisalignCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [31:0] adr, input logic [7:0] msk,
                       input logic [63:0] dat, input logic lst);
      check({tag, ".valid"}, BusValid, 1'b1);
      check({tag, ".adr"}, BusAdr, adr);
      check({tag, ".mask"}, BusByteMask, msk);
      check({tag, ".data"}, BusData, dat);
      check({tag, ".last"}, BusLast, lst);
   endtask

   task automatic idle_bus(input string tag);
      check({tag, ".valid"}, BusValid, 1'b0);
      check({tag, ".mask"}, BusByteMask, 8'h00);
      check({tag, ".last"}, BusLast, 1'b0);
   endtask

   // Present a request, wait (bounded) for acceptance, return at edge+1 after the handshake.
   task automatic send(input logic [2:0] sz, input logic [31:0] adr, input logic [63:0] dat);
      int n;
      ReqValid = 1'b1;
      ReqSize  = sz;
      ReqAdr   = adr;
      ReqData  = dat;
      #1;
      n = 0;
      while (!ReqReady && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept", ReqReady, 1'b1);
      @(posedge clk); #1;
      ReqValid = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      ReqValid = 1'b0;
      ReqSize  = 3'b000;
      ReqAdr   = '0;
      ReqData  = '0;
      BusReady = 1'b0;

      // Reset state, and a request offered during reset must be dropped.
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst.ready", ReqReady, 1'b1);
      idle_bus("rst");
      check("rst.adr", BusAdr, 32'h0);
      check("rst.data", BusData, 64'h0);
      check("rst.count", MisalignCount, 16'h0);
      ReqValid = 1'b1; ReqSize = 3'b011; ReqAdr = 32'h3000; ReqData = 64'hDEAD;
      @(posedge clk); #1;
      ReqValid = 1'b0;
      reset    = 1'b0;
      @(posedge clk); #1;
      idle_bus("rstreq");

      // Aligned double store.
      send(3'b011, 32'h1000, 64'h1122334455667788);
      beat("sd", 32'h1000, 8'hFF, 64'h1122334455667788, 1'b1);
      check("sd.count", MisalignCount, 16'd0);
      check("sd.ready_stall", ReqReady, 1'b0);
      BusReady = 1'b1; #1;
      check("sd.ready_done", ReqReady, 1'b1);
      @(posedge clk); #1;
      idle_bus("sd.after");
      BusReady = 1'b0;

      // Split word store with 3 cycles of backpressure on beat 0 (bit 2 of size set: ignored).
      send(3'b110, 32'h1006, 64'hAABBCCDD);
      for (int i = 0; i < 3; i++) begin
         beat("sw.b0", 32'h1000, 8'hC0, 64'hCCDD000000000000, 1'b0);
         check("sw.b0.ready", ReqReady, 1'b0);
         @(posedge clk); #1;
      end
      beat("sw.b0", 32'h1000, 8'hC0, 64'hCCDD000000000000, 1'b0);
      check("sw.count", MisalignCount, 16'd1);
      BusReady = 1'b1;
      @(posedge clk); #1;
      beat("sw.b1", 32'h1008, 8'h03, 64'h000000000000AABB, 1'b1);
      check("sw.b1.ready", ReqReady, 1'b1);
      @(posedge clk); #1;
      idle_bus("sw.after");
      BusReady = 1'b0;

      // Back-to-back: byte store, then a half store accepted as its beat completes.
      send(3'b000, 32'h2003, 64'h5A);
      beat("sb", 32'h2000, 8'h08, 64'h000000005A000000, 1'b1);
      ReqValid = 1'b1; ReqSize = 3'b001; ReqAdr = 32'h2004; ReqData = 64'h1234;
      BusReady = 1'b1;
      #1;
      check("b2b.ready", ReqReady, 1'b1);
      @(posedge clk); #1;
      ReqValid = 1'b0;
      beat("sh", 32'h2000, 8'h30, 64'h0000123400000000, 1'b1);
      @(posedge clk); #1;
      idle_bus("sh.after");
      check("b2b.count", MisalignCount, 16'd1);
      BusReady = 1'b0;

      // Address wrap on a split half store.
      send(3'b001, 32'hFFFFFFFF, 64'hBEEF);
      beat("wrap.b0", 32'hFFFFFFF8, 8'h80, 64'hEF00000000000000, 1'b0);
      check("wrap.count", MisalignCount, 16'd2);
      BusReady = 1'b1;
      @(posedge clk); #1;
      beat("wrap.b1", 32'h00000000, 8'h01, 64'h00000000000000BE, 1'b1);
      @(posedge clk); #1;
      idle_bus("wrap.after");
      BusReady = 1'b0;

      // Reset while the second beat is pending.
      send(3'b010, 32'h1006, 64'hAABBCCDD);
      check("rs.count", MisalignCount, 16'd3);
      BusReady = 1'b1;
      @(posedge clk); #1;
      BusReady = 1'b0;
      beat("rs.b1", 32'h1008, 8'h03, 64'h000000000000AABB, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      idle_bus("rs.after");
      check("rs.ready", ReqReady, 1'b1);
      check("rs.count0", MisalignCount, 16'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      idle_bus("rs.quiet");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
